// File: rtl/ig_pkg.sv
// Shared definitions for the ingress buffer: request size codes, bridge size
// encodings, entry field widths and the per-lane write-data alignment helpers.
package ig_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ISZ_BYTE = 2'b01;
  localparam logic [1:0] ISZ_HALF = 2'b10;
  localparam logic [1:0] ISZ_WORD = 2'b00;

  // Entry layout, LSB first: data[DW], size code[2], addr[AW], wr[1]
  localparam int ENT_SZ_W = 2;
  localparam int ENT_WR_W = 1;

  function automatic logic [1:0] enc_size(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: enc_size = ISZ_BYTE;
      SZ_HALF: enc_size = ISZ_HALF;
      default: enc_size = ISZ_WORD;
    endcase
  endfunction

  // Byte always shifts down; a half at offset 3 would straddle lanes, so it passes through.
  function automatic logic needs_align(input logic [1:0] sz, input logic [1:0] off);
    needs_align = (sz == SZ_BYTE) || ((sz == SZ_HALF) && (off != 2'd3));
  endfunction

  function automatic logic [31:0] align_lane(input logic [1:0] sz, input logic [1:0] off,
                                             input logic [31:0] lane);
    logic [31:0] shifted;
    shifted = lane >> {off, 3'b000};
    if (sz == SZ_BYTE) align_lane = {24'h0, shifted[7:0]};
    else               align_lane = {16'h0, shifted[15:0]};
  endfunction

endpackage

// File: rtl/ig_sync_fifo.sv
// Registered synchronous FIFO with full/empty/count; head entry is read
// directly from storage so it holds steady until popped.
module ig_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               din_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               dout_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/ingress_buf.sv
// Ingress port: aligns write data, queues requests towards the bridge,
// throttles reads on outstanding credit and registers read responses.
module ingress_buf
  import ig_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 7,
  parameter int DEPTH  = 4,
  parameter int MAX_RD = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             wr_rd_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [1:0]       size_i,
  input  logic [DW-1:0]    wdata_i,
  output logic             rvalid_o,
  input  logic             rd_ready_i,
  output logic [DW-1:0]    rdata_o,
  output logic             int_valid_o,
  input  logic             int_ready_i,
  output logic             int_wr_o,
  output logic [1:0]       int_size_o,
  output logic [AW+DW-1:0] int_addr_data_o,
  input  logic             int_rvalid_i,
  output logic             int_rready_o,
  input  logic [DW-1:0]    int2ig_data_i,
  output logic [3:0]       rd_outstanding_o
);

  localparam int ENT_W    = ENT_WR_W + AW + ENT_SZ_W + DW;
  localparam int SZ_LSB   = DW;
  localparam int ADDR_LSB = DW + ENT_SZ_W;
  localparam int WR_BIT   = DW + ENT_SZ_W + AW;
  localparam int LANES    = DW / 32;
  localparam int CW       = $clog2(DEPTH + 1);

  logic [31:0]      lane_w;
  logic [DW-1:0]    aligned_w;
  logic [ENT_W-1:0] ent_in, ent_head;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             push, pop, push_rd, pop_rd, ret;
  logic             rd_credit_ok;
  logic [3:0]       rd_out_q, rd_out_d;
  logic [3:0]       rd_queued_q, rd_queued_d;
  logic             rvalid_q, rvalid_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  if (LANES > 1) begin : g_lane_sel
    localparam int LSW = $clog2(LANES);
    assign lane_w = wdata_i[32*addr_i[LSW+1:2] +: 32];
  end else begin : g_lane_one
    assign lane_w = wdata_i[31:0];
  end

  always_comb begin
    aligned_w = wdata_i;
    if (needs_align(size_i, addr_i[1:0])) begin
      aligned_w       = '0;
      aligned_w[31:0] = align_lane(size_i, addr_i[1:0], lane_w);
    end
  end

  assign ent_in = {wr_rd_i, addr_i, enc_size(size_i), aligned_w};

  // Credit counts reads still queued, so a burst of reads cannot overrun MAX_RD
  assign rd_credit_ok = ({1'b0, rd_out_q} + {1'b0, rd_queued_q}) < 5'(MAX_RD);
  assign ready_o      = !fifo_full && (wr_rd_i || rd_credit_ok);

  assign push    = valid_i && ready_o;
  assign pop     = int_valid_o && int_ready_i;
  assign push_rd = push && !wr_rd_i;
  assign pop_rd  = pop && !int_wr_o;
  assign ret     = int_rvalid_i && int_rready_o;

  ig_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .din_i   (ent_in),
    .pop_i   (pop),
    .dout_o  (ent_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign int_valid_o     = !fifo_empty;
  assign int_wr_o        = ent_head[WR_BIT];
  assign int_size_o      = ent_head[SZ_LSB +: ENT_SZ_W];
  assign int_addr_data_o = {ent_head[ADDR_LSB +: AW], ent_head[DW-1:0]};

  assign int_rready_o     = !rvalid_q || rd_ready_i;
  assign rvalid_o         = rvalid_q;
  assign rdata_o          = rdata_q;
  assign rd_outstanding_o = rd_out_q;

  always_comb begin
    rd_out_d    = rd_out_q;
    rd_queued_d = rd_queued_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    case ({pop_rd, ret})
      2'b10:   rd_out_d = rd_out_q + 4'd1;
      2'b01:   rd_out_d = rd_out_q - 4'd1;
      default: rd_out_d = rd_out_q;
    endcase
    case ({push_rd, pop_rd})
      2'b10:   rd_queued_d = rd_queued_q + 4'd1;
      2'b01:   rd_queued_d = rd_queued_q - 4'd1;
      default: rd_queued_d = rd_queued_q;
    endcase
    if (ret) begin
      rvalid_d = 1'b1;
      rdata_d  = int2ig_data_i;
    end else if (rd_ready_i) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_out_q    <= '0;
      rd_queued_q <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rd_out_q    <= rd_out_d;
      rd_queued_q <= rd_queued_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  a_no_rd_underflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    ret |-> (rd_out_q != 4'd0));

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    fifo_count <= CW'(DEPTH));

endmodule

// File: tb/tb_ingress_buf.sv
// Directed-vector bench for ingress_buf with hand-computed expectations.
module tb_ingress_buf;

  localparam int DW = 32;
  localparam int AW = 7;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic             valid_i;
  logic             ready_o;
  logic             wr_rd_i;
  logic [AW-1:0]    addr_i;
  logic [1:0]       size_i;
  logic [DW-1:0]    wdata_i;
  logic             rvalid_o;
  logic             rd_ready_i;
  logic [DW-1:0]    rdata_o;
  logic             int_valid_o;
  logic             int_ready_i;
  logic             int_wr_o;
  logic [1:0]       int_size_o;
  logic [AW+DW-1:0] int_addr_data_o;
  logic             int_rvalid_i;
  logic             int_rready_o;
  logic [DW-1:0]    int2ig_data_i;
  logic [3:0]       rd_outstanding_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  ingress_buf #(.DW(DW), .AW(AW), .DEPTH(4), .MAX_RD(2)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .wr_rd_i          (wr_rd_i),
    .addr_i           (addr_i),
    .size_i           (size_i),
    .wdata_i          (wdata_i),
    .rvalid_o         (rvalid_o),
    .rd_ready_i       (rd_ready_i),
    .rdata_o          (rdata_o),
    .int_valid_o      (int_valid_o),
    .int_ready_i      (int_ready_i),
    .int_wr_o         (int_wr_o),
    .int_size_o       (int_size_o),
    .int_addr_data_o  (int_addr_data_o),
    .int_rvalid_i     (int_rvalid_i),
    .int_rready_o     (int_rready_o),
    .int2ig_data_i    (int2ig_data_i),
    .rd_outstanding_o (rd_outstanding_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Called at posedge+1; returns at the next posedge+1 with valid dropped.
  task automatic push(input logic wr, input logic [AW-1:0] a, input logic [1:0] sz,
                      input logic [DW-1:0] d);
    valid_i = 1'b1;
    wr_rd_i = wr;
    addr_i  = a;
    size_i  = sz;
    wdata_i = d;
    #1;
    chk("push_ready", 64'(ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic wr_align(input string tag, input logic [AW-1:0] a, input logic [1:0] sz,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_d,
                          input logic [1:0] exp_sz);
    push(1'b1, a, sz, d);
    chk({tag, "_valid"}, 64'(int_valid_o), 64'd1);
    chk({tag, "_data"}, 64'(int_addr_data_o), 64'({a, exp_d}));
    chk({tag, "_size"}, 64'(int_size_o), 64'(exp_sz));
    chk({tag, "_wr"}, 64'(int_wr_o), 64'd1);
    int_ready_i = 1'b1;
    step();
    int_ready_i = 1'b0;
    chk({tag, "_drained"}, 64'(int_valid_o), 64'd0);
  endtask

  logic [DW-1:0] wdat [4];

  initial begin
    rst_n_i       = 1'b0;
    valid_i       = 1'b0;
    wr_rd_i       = 1'b0;
    addr_i        = '0;
    size_i        = 2'b00;
    wdata_i       = '0;
    rd_ready_i    = 1'b1;
    int_ready_i   = 1'b0;
    int_rvalid_i  = 1'b0;
    int2ig_data_i = '0;
    wdat[0] = 32'h1000_0001;
    wdat[1] = 32'h2000_0002;
    wdat[2] = 32'h3000_0003;
    wdat[3] = 32'h4000_0004;

    // Reset state
    #12;
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_int_valid", 64'(int_valid_o), 64'd0);
    chk("rst_rvalid", 64'(rvalid_o), 64'd0);
    chk("rst_rdata", 64'(rdata_o), 64'd0);
    chk("rst_rd_out", 64'(rd_outstanding_o), 64'd0);
    chk("rst_int_wr", 64'(int_wr_o), 64'd0);
    chk("rst_int_size", 64'(int_size_o), 64'd0);
    chk("rst_int_ad", 64'(int_addr_data_o), 64'd0);
    #10;
    rst_n_i = 1'b1;
    step();

    // 1: byte write, latency 1
    wr_align("t1_byte", 7'h05, 2'b00, 32'hAABBCCDD, 32'h0000_00CC, 2'b01);

    // 2: fill FIFO, then drain in order
    for (int i = 0; i < 4; i++) push(1'b1, 7'(8'h10 + 4 * i), 2'b10, wdat[i]);
    chk("t2_full_ready", 64'(ready_o), 64'd0);
    chk("t2_head0", 64'(int_addr_data_o), 64'({7'h10, wdat[0]}));
    int_ready_i = 1'b1;
    #1;
    chk("t2_ready_before_pop", 64'(ready_o), 64'd0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("t2_ready_after_pop", 64'(ready_o), 64'd1);
      chk("t2_head", 64'(int_addr_data_o), 64'({7'(8'h10 + 4 * i), wdat[i]}));
      chk("t2_head_size", 64'(int_size_o), 64'd0);
    end
    step();
    chk("t2_empty", 64'(int_valid_o), 64'd0);

    // 3: read credit throttling at MAX_RD=2
    push(1'b0, 7'h20, 2'b10, '0);
    push(1'b0, 7'h24, 2'b10, '0);
    valid_i = 1'b1;
    wr_rd_i = 1'b0;
    addr_i  = 7'h28;
    #1;
    chk("t3_stall", 64'(ready_o), 64'd0);
    chk("t3_rd_out1", 64'(rd_outstanding_o), 64'd1);
    @(posedge clk_i);
    #1;
    chk("t3_stall2", 64'(ready_o), 64'd0);
    chk("t3_rd_out2", 64'(rd_outstanding_o), 64'd2);
    int_rvalid_i  = 1'b1;
    int2ig_data_i = 32'hCAFE_0001;
    step();
    int_rvalid_i = 1'b0;
    chk("t3_rd_out_ret", 64'(rd_outstanding_o), 64'd1);
    chk("t3_ready_credit", 64'(ready_o), 64'd1);
    chk("t3_rvalid", 64'(rvalid_o), 64'd1);
    chk("t3_rdata", 64'(rdata_o), 64'hCAFE_0001);
    step();
    valid_i = 1'b0;
    chk("t3_rvalid_clr", 64'(rvalid_o), 64'd0);
    chk("t3_third_queued", 64'(int_valid_o), 64'd1);
    step();
    chk("t3_rd_out_final", 64'(rd_outstanding_o), 64'd2);

    // 4: response stage back-pressure
    rd_ready_i    = 1'b0;
    int_rvalid_i  = 1'b1;
    int2ig_data_i = 32'h1234_5678;
    step();
    int_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_rvalid_hold", 64'(rvalid_o), 64'd1);
      chk("t4_rdata_hold", 64'(rdata_o), 64'h1234_5678);
      chk("t4_int_rready", 64'(int_rready_o), 64'd0);
      step();
    end
    rd_ready_i = 1'b1;
    #1;
    chk("t4_int_rready_open", 64'(int_rready_o), 64'd1);
    step();
    chk("t4_rvalid_clr", 64'(rvalid_o), 64'd0);
    chk("t4_rd_out", 64'(rd_outstanding_o), 64'd1);
    int_rvalid_i  = 1'b1;
    int2ig_data_i = 32'h55AA_55AA;
    step();
    int_rvalid_i = 1'b0;
    chk("t4_last_rdata", 64'(rdata_o), 64'h55AA_55AA);
    chk("t4_rd_out_zero", 64'(rd_outstanding_o), 64'd0);
    step();
    chk("t4_last_clr", 64'(rvalid_o), 64'd0);

    // 5: alignment vectors
    int_ready_i = 1'b0;
    wr_align("t5_half3", 7'h03, 2'b01, 32'h11223344, 32'h1122_3344, 2'b10);
    wr_align("t5_half2", 7'h02, 2'b01, 32'h11223344, 32'h0000_1122, 2'b10);
    wr_align("t5_half1", 7'h41, 2'b01, 32'h11223344, 32'h0000_2233, 2'b10);
    wr_align("t5_byte0", 7'h00, 2'b00, 32'h11223344, 32'h0000_0044, 2'b01);
    wr_align("t5_byte3", 7'h07, 2'b00, 32'h11223344, 32'h0000_0011, 2'b01);
    wr_align("t5_word", 7'h0C, 2'b10, 32'hDEADBEEF, 32'hDEAD_BEEF, 2'b00);
    wr_align("t5_rsvd", 7'h01, 2'b11, 32'h0BADF00D, 32'h0BAD_F00D, 2'b00);

    // 6: async reset mid-operation
    int_ready_i = 1'b1;
    rd_ready_i  = 1'b0;
    push(1'b0, 7'h30, 2'b10, '0);
    push(1'b0, 7'h34, 2'b10, '0);
    step();
    int_ready_i   = 1'b0;
    int_rvalid_i  = 1'b1;
    int2ig_data_i = 32'h0000_BEEF;
    step();
    int_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) push(1'b1, 7'(8'h40 + 4 * i), 2'b10, wdat[i]);
    chk("t6_pre_int_valid", 64'(int_valid_o), 64'd1);
    chk("t6_pre_rvalid", 64'(rvalid_o), 64'd1);
    chk("t6_pre_rd_out", 64'(rd_outstanding_o), 64'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("t6_int_valid", 64'(int_valid_o), 64'd0);
    chk("t6_rvalid", 64'(rvalid_o), 64'd0);
    chk("t6_rd_out", 64'(rd_outstanding_o), 64'd0);
    #10;
    rst_n_i    = 1'b1;
    rd_ready_i = 1'b1;
    step();
    chk("t6_post_ready", 64'(ready_o), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, expected bench completion");
    $fatal(1);
  end

endmodule
